// File: rtl/forward_select_unit_pkg.sv
// Shared CPU types for operand forwarding and hazard control.
// Select codes, FSM states and scoreboard entry record.
package forward_select_unit_pkg;

  typedef enum logic [1:0] {
    SEL_RF    = 2'b00,
    SEL_EXMEM = 2'b01,
    SEL_MEMWB = 2'b10,
    SEL_WBBUF = 2'b11
  } fwd_sel_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } fsm_state_e;

  typedef enum logic [1:0] {
    ADV_NORMAL = 2'b00,
    ADV_BUBBLE = 2'b01,
    ADV_HOLD   = 2'b10
  } adv_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_write;
  } sb_key_t;

  typedef struct packed {
    sb_key_t key;
    logic    load;
    logic    muldiv;
  } sb_entry_t;

  localparam sb_entry_t SB_BUBBLE = '0;

  function automatic logic sb_hit(
    input sb_key_t    k,
    input logic [4:0] rs
  );
    return k.valid && k.reg_write &&
           (k.rd == rs) && (rs != 5'd0);
  endfunction

endpackage

// File: rtl/forward_select_unit_fwd_match.sv
// Forward select for one source register.
// Youngest matching producer wins.
module fwd_match
  import forward_select_unit_pkg::*;
(
  input  logic [4:0] rs,
  input  sb_key_t    ex_k,
  input  sb_key_t    mem_k,
  input  sb_key_t    wb_k,
  output logic [1:0] sel
);

  // Priority pick EX > MEM > WB > register file
  always_comb begin
    sel = SEL_RF;
    if (sb_hit(ex_k, rs))
      sel = SEL_EXMEM;
    else if (sb_hit(mem_k, rs))
      sel = SEL_MEMWB;
    else if (sb_hit(wb_k, rs))
      sel = SEL_WBBUF;
  end

endmodule

// File: rtl/forward_select_unit.sv
// Forwarding select and load-use / multi-cycle stall control.
// Tracks EX, MEM, WB producers in a 3-entry scoreboard.
module forward_select_unit
  import forward_select_unit_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  input  logic [4:0] ID_RS1,
  input  logic [4:0] ID_RS2,
  input  logic [4:0] ID_RD,
  input  logic       ID_VALID,
  input  logic       ID_REG_WRITE,
  input  logic       ID_MEM_READ,
  input  logic       ID_MULDIV,
  input  logic       MULDIV_DONE,
  output logic [1:0] FWD_SEL1,
  output logic [1:0] FWD_SEL2,
  output logic       STALL,
  output logic       BUSY
);

  sb_entry_t  ex_q, mem_q, wb_q;
  sb_entry_t  id_e;
  fsm_state_e state_q, state_d;
  adv_e       adv;
  logic [1:0] sel1_d, sel2_d;
  logic [1:0] sel1_q, sel2_q;
  logic       op_start;
  logic       lu_raw;
  logic       lu;

  fwd_match u_match1 (
    .rs    (ID_RS1),
    .ex_k  (ex_q.key),
    .mem_k (mem_q.key),
    .wb_k  (wb_q.key),
    .sel   (sel1_d)
  );

  fwd_match u_match2 (
    .rs    (ID_RS2),
    .ex_k  (ex_q.key),
    .mem_k (mem_q.key),
    .wb_k  (wb_q.key),
    .sel   (sel2_d)
  );

  // ID fields packed into an entry; invalid ID becomes a bubble
  always_comb begin
    id_e = SB_BUBBLE;
    if (ID_VALID) begin
      id_e.key.valid     = 1'b1;
      id_e.key.rd        = ID_RD;
      id_e.key.reg_write = ID_REG_WRITE;
      id_e.load          = ID_MEM_READ;
      id_e.muldiv        = ID_MULDIV;
    end
  end

  // Hazard detection on the entry currently in EX
  always_comb begin
    op_start = (state_q == ST_IDLE) &&
               ex_q.key.valid && ex_q.muldiv &&
               !MULDIV_DONE;
    lu_raw   = ID_VALID && ex_q.load &&
               (sb_hit(ex_q.key, ID_RS1) ||
                sb_hit(ex_q.key, ID_RS2));
  end

  // FSM state register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (op_start)    state_d = ST_BUSY;
      ST_BUSY: if (MULDIV_DONE) state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: stall, busy and scoreboard advance mode.
  // The op is kept in EX from the edge it is first seen not done.
  always_comb begin
    BUSY  = (state_q == ST_BUSY);
    lu    = lu_raw && !BUSY;
    STALL = lu || BUSY;
    adv   = ADV_NORMAL;
    unique case (1'b1)
      op_start:              adv = ADV_HOLD;
      BUSY && !MULDIV_DONE:  adv = ADV_HOLD;
      lu:                    adv = ADV_BUBBLE;
      default:               adv = ADV_NORMAL;
    endcase
  end

  // Scoreboard shift and registered forward selects
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ex_q   <= SB_BUBBLE;
      mem_q  <= SB_BUBBLE;
      wb_q   <= SB_BUBBLE;
      sel1_q <= SEL_RF;
      sel2_q <= SEL_RF;
    end else begin
      unique case (adv)
        ADV_HOLD: begin
          mem_q <= SB_BUBBLE;
          wb_q  <= mem_q;
        end
        ADV_BUBBLE: begin
          ex_q   <= SB_BUBBLE;
          mem_q  <= ex_q;
          wb_q   <= mem_q;
          sel1_q <= SEL_RF;
          sel2_q <= SEL_RF;
        end
        default: begin
          ex_q   <= id_e;
          mem_q  <= ex_q;
          wb_q   <= mem_q;
          sel1_q <= sel1_d;
          sel2_q <= sel2_d;
        end
      endcase
    end
  end

  assign FWD_SEL1 = sel1_q;
  assign FWD_SEL2 = sel2_q;

endmodule

// File: doc/forward_select_unit.md
FORWARD_SELECT_UNIT -- requirements
Module: forward_select_unit

Interface
REQ-001 SHALL have ports: CLK  in  1  single clock, rising-edge; RESET  in  1  asynchronous, active-low reset.
REQ-002 SHALL have inputs: ID_RS1, ID_RS2  in  5 each  source registers of the ID-stage instruction.
REQ-003 SHALL have inputs: ID_RD  in  5  destination; ID_VALID  in  1  ID holds a real instruction; ID_REG_WRITE  in  1  writes rd; ID_MEM_READ  in  1  is a load.
REQ-004 SHALL have inputs: ID_MULDIV  in  1  is a multi-cycle M-extension op; MULDIV_DONE  in  1  multi-cycle result ready this cycle.
REQ-005 SHALL have outputs: FWD_SEL1, FWD_SEL2  out  2 each  operand-mux selects for the instruction currently in EX.
REQ-006 SHALL have outputs: STALL  out  1  hold PC and IF/ID; BUSY  out  1  multi-cycle op in progress.
REQ-007 SHALL use select codes 00 register file, 01 EX/MEM ALU result, 10 MEM/WB result, 11 write-back buffer.

Function
REQ-008 SHALL keep a 3-entry scoreboard {valid, rd, reg_write, load, muldiv} for the EX, MEM and WB stages.
REQ-009 An entry SHALL match rs only if valid, reg_write, rd == rs and rs != 0.
REQ-010 SHALL compute each select against the ID instruction: EX-entry match gives 01; else MEM-entry match gives 10; else WB-entry match gives 11; else 00.
REQ-011 Priority SHALL be EX > MEM > WB (youngest producer wins).
REQ-012 SHALL register FWD_SEL1/2 on the clock, so codes are valid the cycle the consumer occupies EX (1-cycle latency).
REQ-013 Load-use: STALL SHALL be asserted combinationally when the EX entry is a load matching ID_RS1 or ID_RS2 with ID_VALID=1.
REQ-014 On a load-use STALL edge, the scoreboard SHALL do EX<=bubble (valid=0), MEM<=EX, WB<=MEM, and FWD_SEL1/2<=00.
REQ-015 Normal advance (no STALL, IDLE) SHALL do EX<=ID fields gated by ID_VALID, MEM<=EX, WB<=MEM.
REQ-016 FSM SHALL have states IDLE and BUSY; BUSY SHALL equal (state==BUSY).
REQ-017 IDLE->BUSY SHALL occur on the edge where the EX entry has muldiv=1 and MULDIV_DONE=0.
REQ-018 If MULDIV_DONE=1 in that same cycle, the FSM SHALL stay IDLE and advance normally.
REQ-019 In BUSY, STALL SHALL be 1 and the EX entry and FWD_SEL1/2 SHALL be held.
REQ-020 In BUSY, each edge SHALL do MEM<=bubble, WB<=MEM.
REQ-021 BUSY->IDLE SHALL occur on the edge where MULDIV_DONE=1, with a normal advance on that edge.
REQ-022 STALL SHALL be the OR of load-use and BUSY, and a load-use hit during BUSY SHALL be ignored until IDLE.
REQ-023 ID_VALID=0 SHALL never cause STALL and SHALL insert a bubble into EX.

Reset
REQ-024 RESET low SHALL asynchronously clear all scoreboard valid bits, FWD_SEL1/2=00, state=IDLE, STALL=0 and BUSY=0.
REQ-025 RESET asserted mid-BUSY SHALL abandon the op; after release the first edge SHALL perform a normal advance.

Structure
REQ-026 Select codes (2-bit), state encodings and the scoreboard entry record SHALL live in the shared CPU package.
REQ-027 One sub-module, fwd_match, SHALL compute the 2-bit select for a single rs against three entries and SHALL be instantiated twice.

Verification
REQ-028 addi x5 then add x6,x5,x0 back-to-back -> FWD_SEL1=01 in the consumer's EX cycle, STALL=0.
REQ-029 Producer x7, one independent instruction, then consumer rs2=x7 -> FWD_SEL2=10; with two independent instructions between -> 11; with three -> 00.
REQ-030 lw x8 then add x9,x8,x8 -> STALL=1 for exactly one cycle, next EX cycle FWD_SEL1=FWD_SEL2=10.
REQ-031 Producer rd=x0 followed by consumer rs1=x0 -> FWD_SEL1=00, no STALL.
REQ-032 div in EX with MULDIV_DONE low 5 cycles -> BUSY=STALL=1 for 5 cycles; DONE pulse -> IDLE on that edge, and a dependent consumer gets 01.
REQ-033 RESET pulsed low during BUSY -> immediate STALL=0, BUSY=0, selects 00; post-release instructions forward correctly.
